rom_bus_arbiter: RTL

//   Shares one ROM slave bus (req/gnt/addr, rvalid/rdata/err response) between two

---
 rtl/rom_bus_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rom_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single ROM slave bus.
// An in-order ID FIFO steers each slave response back to the master that issued the read.
module rom_bus_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    output logic                  m0_err_o,
    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  m1_err_o,
    output logic                  slv_req_o,
    output logic [ADDR_WIDTH-1:0] slv_addr_o,
    input  logic                  slv_gnt_i,
    input  logic                  slv_rvalid_i,
    input  logic [DATA_WIDTH-1:0] slv_rdata_i,
    input  logic                  slv_err_i,
    output logic                  protocol_err_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

    logic [MAX_OUTSTANDING-1:0] id_q, id_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       last_gnt_q, last_gnt_d;
    logic                       protocol_err_q, protocol_err_d;

    logic full_s;
    logic any_req_s;
    logic winner_s;
    logic accept_s;
    logic pop_s;
    logic head_s;

    // Pointer increment with explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Request channel: winner selection, slave request and zero-cycle grants.
    always_comb begin
        full_s    = (count_q == CNT_MAX);
        any_req_s = m0_req_i | m1_req_i;
        if (m0_req_i && m1_req_i) begin
            winner_s = ~last_gnt_q;
        end else if (m1_req_i) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
        slv_req_o = any_req_s & ~full_s & ~rst_i;
        if (any_req_s) begin
            slv_addr_o = winner_s ? m1_addr_i : m0_addr_i;
        end else begin
            slv_addr_o = {ADDR_WIDTH{1'b0}};
        end
        accept_s = slv_req_o & slv_gnt_i;
        m0_gnt_o = accept_s & ~winner_s;
        m1_gnt_o = accept_s & winner_s;
    end

    // Response channel: route the slave response to the master at the FIFO head.
    always_comb begin
        head_s      = id_q[rd_ptr_q];
        pop_s       = slv_rvalid_i & (count_q != {CNT_W{1'b0}}) & ~rst_i;
        m0_rvalid_o = pop_s & ~head_s;
        m1_rvalid_o = pop_s & head_s;
        if (m0_rvalid_o) begin
            m0_rdata_o = slv_rdata_i;
            m0_err_o   = slv_err_i;
        end else begin
            m0_rdata_o = {DATA_WIDTH{1'b0}};
            m0_err_o   = 1'b0;
        end
        if (m1_rvalid_o) begin
            m1_rdata_o = slv_rdata_i;
            m1_err_o   = slv_err_i;
        end else begin
            m1_rdata_o = {DATA_WIDTH{1'b0}};
            m1_err_o   = 1'b0;
        end
        protocol_err_o = protocol_err_q;
    end

    // Next-state for ID FIFO, round-robin history and the sticky protocol error.
    always_comb begin
        id_d = id_q;
        if (accept_s) begin
            id_d[wr_ptr_q] = winner_s;
            wr_ptr_d       = ptr_inc(wr_ptr_q);
            last_gnt_d     = winner_s;
        end else begin
            wr_ptr_d   = wr_ptr_q;
            last_gnt_d = last_gnt_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({accept_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        protocol_err_d = protocol_err_q | (slv_rvalid_i & (count_q == {CNT_W{1'b0}}));
    end

    // State registers; last_gnt resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_q           <= {MAX_OUTSTANDING{1'b0}};
            wr_ptr_q       <= {PTR_W{1'b0}};
            rd_ptr_q       <= {PTR_W{1'b0}};
            count_q        <= {CNT_W{1'b0}};
            last_gnt_q     <= 1'b1;
            protocol_err_q <= 1'b0;
        end else begin
            id_q           <= id_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            last_gnt_q     <= last_gnt_d;
            protocol_err_q <= protocol_err_d;
        end
    end

endmodule
